// File: rtl/my_pkg.sv
// ---------------------------------------------------------------------------
// my_pkg
// Shared definitions for the bidirectional-bus FIFO master.
//   DATA_WIDTH    : default width of client write/read data and the FIFO bus
//   bidi_state_e  : debug view of what the master/bus is doing
//                   IDLE - nothing happening
//                   WR   - push on the bus
//                   RD   - pop issued / FIFO returning data
//                   TURN - bus turnaround dead time after a FIFO-driven cycle
// ---------------------------------------------------------------------------
package my_pkg;

    localparam int DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2,
        TURN = 2'd3
    } bidi_state_e;

endpackage

// File: rtl/bidi_bus_drv.sv
// ---------------------------------------------------------------------------
// bidi_bus_drv
// Tri-state driver for the shared FIFO data bus. This is the only place in
// the master that drives the bus; when oe is low every bit floats.
// Ports:
//   oe   in     1           output enable (high only during push cycles)
//   d    in     DATA_WIDTH  value to drive
//   bus  inout  DATA_WIDTH  shared bidirectional bus
// ---------------------------------------------------------------------------
module bidi_bus_drv #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  oe,
    input  logic [DATA_WIDTH-1:0] d,
    inout  wire  [DATA_WIDTH-1:0] bus
);

    // Per-bit drivers so each bus line is an independent tri-state buffer.
    for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_bit
        assign bus[gi] = oe ? d[gi] : 1'bz;
    end

endmodule

// File: rtl/fifo_bidi_master.sv
// ---------------------------------------------------------------------------
// fifo_bidi_master
// Client-side sequencer for a single-clock FIFO whose data port is a shared
// bidirectional bus. Turns a valid/ready write channel and a request/response
// read channel into FIFO push/pop strobes, owns the bus output enable and
// keeps a turnaround gap so the master never drives while the FIFO might.
//
// Bus contract:
//   push in cycle N -> master drives fifo_data in N, FIFO samples at end of N
//   pop  in cycle N -> FIFO drives fifo_data in N+1, master samples at end N+1
//   => read data appears on rd_data/rd_data_valid two cycles after accept.
//
// Ports:
//   clock          in     1           single clock, rising edge
//   reset          in     1           synchronous, active-high
//   wr_valid       in     1           client write request
//   wr_ready       out    1           write accepted when wr_valid & wr_ready
//   wr_data        in     DATA_WIDTH  write data
//   rd_req_valid   in     1           client read request
//   rd_req_ready   out    1           read accepted when rd_req_valid & rd_req_ready
//   rd_data_valid  out    1           one-cycle pulse, rd_data valid
//   rd_data        out    DATA_WIDTH  registered read data
//   fifo_push      out    1           push strobe to FIFO
//   fifo_pop       out    1           pop strobe to FIFO
//   fifo_full      in     1           FIFO full (state after last edge)
//   fifo_empty     in     1           FIFO empty (state after last edge)
//   fifo_data      inout  DATA_WIDTH  shared bus; driven here only on push
// ---------------------------------------------------------------------------
module fifo_bidi_master #(
    parameter int DATA_WIDTH = my_pkg::DATA_WIDTH,
    parameter int TURN_CYC   = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_req_valid,
    output logic                  rd_req_ready,
    output logic                  rd_data_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  fifo_push,
    output logic                  fifo_pop,
    input  logic                  fifo_full,
    input  logic                  fifo_empty,
    inout  wire  [DATA_WIDTH-1:0] fifo_data
);

    import my_pkg::*;

    localparam int TW = (TURN_CYC < 1) ? 1 : $clog2(TURN_CYC + 1);
    localparam logic [TW-1:0] TURN_LOAD = TW'(TURN_CYC);

    // State
    logic                  rd_pend_reg;       // FIFO drives the bus this cycle
    logic [TW-1:0]         turn_cnt_reg;      // remaining dead cycles before a push
    logic [TW-1:0]         turn_cnt_next;
    logic                  last_grant_reg;    // 0: write went last, 1: read went last
    logic                  rd_data_valid_reg;
    logic [DATA_WIDTH-1:0] rd_data_reg;
    bidi_state_e           state_reg;
    bidi_state_e           state_next;

    // Arbitration
    logic wr_elig;
    logic rd_elig;
    logic grant_wr;

    // A write is only eligible when the bus is guaranteed quiet: no data
    // returning this cycle and the turnaround counter expired. A write that
    // is ineligible never holds off a read.
    assign wr_elig = wr_valid & ~fifo_full & ~rd_pend_reg & (turn_cnt_reg == '0);
    assign rd_elig = rd_req_valid & ~fifo_empty;

    // Tie-break: the channel that did not go last wins. After reset
    // last_grant_reg is 0 (write last), so the first tie goes to the read.
    assign grant_wr = wr_elig & (~rd_elig | last_grant_reg);

    assign wr_ready     = ~reset & grant_wr;
    assign rd_req_ready = ~reset & ~fifo_empty & ~grant_wr;

    // rd_req_ready is forced low whenever grant_wr is high, so push and pop
    // are mutually exclusive by construction.
    assign fifo_push = wr_valid & wr_ready;
    assign fifo_pop  = rd_req_valid & rd_req_ready;

    assign rd_data_valid = rd_data_valid_reg;
    assign rd_data       = rd_data_reg;

    bidi_bus_drv #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_bus_drv (
        .oe  (fifo_push),
        .d   (wr_data),
        .bus (fifo_data)
    );

    // The counter is reloaded in every FIFO-driven cycle, so a burst of
    // back-to-back pops keeps pushing the earliest write slot out.
    always_comb begin
        turn_cnt_next = turn_cnt_reg;
        if (rd_pend_reg) begin
            turn_cnt_next = TURN_LOAD;
        end else if (turn_cnt_reg != '0) begin
            turn_cnt_next = turn_cnt_reg - 1'b1;
        end
    end

    // Debug state: describes the bus activity for the coming cycle.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, WR, RD: begin
                if (fifo_push) begin
                    state_next = WR;
                end else if (fifo_pop) begin
                    state_next = RD;
                end else if (turn_cnt_next != '0) begin
                    state_next = TURN;
                end else begin
                    state_next = IDLE;
                end
            end
            TURN: begin
                if (fifo_pop) begin
                    state_next = RD;
                end else if (turn_cnt_next == '0) begin
                    state_next = IDLE;
                end else begin
                    state_next = TURN;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_pend_reg       <= 1'b0;
            turn_cnt_reg      <= '0;
            last_grant_reg    <= 1'b0;
            rd_data_valid_reg <= 1'b0;
            rd_data_reg       <= '0;
            state_reg         <= IDLE;
        end else begin
            rd_pend_reg       <= fifo_pop;
            turn_cnt_reg      <= turn_cnt_next;
            rd_data_valid_reg <= rd_pend_reg;
            state_reg         <= state_next;
            if (rd_pend_reg) begin
                rd_data_reg <= fifo_data;
            end
            if (fifo_push) begin
                last_grant_reg <= 1'b0;
            end else if (fifo_pop) begin
                last_grant_reg <= 1'b1;
            end
        end
    end

endmodule
